// File: rtl/qar_timer_pkg.sv
// Register map, bit positions and channel mode encodings shared by the timer.
package qar_timer_pkg;

    localparam logic [7:0] ADDR_CTRL    = 8'h00;
    localparam logic [7:0] ADDR_PRESC   = 8'h04;
    localparam logic [7:0] ADDR_COUNT   = 8'h08;
    localparam logic [7:0] ADDR_RELOAD  = 8'h0C;
    localparam logic [7:0] ADDR_STATUS  = 8'h10;
    localparam logic [7:0] ADDR_IRQ_EN  = 8'h14;
    localparam logic [7:0] ADDR_CH_BASE = 8'h20;

    localparam logic [3:0] CH_OFF_CTRL = 4'h0;
    localparam logic [3:0] CH_OFF_CMP  = 4'h4;
    localparam logic [3:0] CH_OFF_CAP  = 4'h8;

    localparam int unsigned CTRL_EN_BIT      = 0;
    localparam int unsigned CTRL_ONESHOT_BIT = 1;
    localparam int unsigned STATUS_OVF_BIT   = 0;
    localparam int unsigned STATUS_CH_LSB    = 1;
    localparam int unsigned CH_MODE_LSB      = 0;
    localparam int unsigned CH_FALL_BIT      = 2;

    typedef enum logic [1:0] {
        MODE_OFF = 2'd0,
        MODE_CMP = 2'd1,
        MODE_PWM = 2'd2,
        MODE_CAP = 2'd3
    } ch_mode_e;

endpackage

// File: rtl/qar_timer_mc_if.sv
// Zero-wait-state register bus between a host and the timer.
interface qar_timer_mc_if;
    logic        bus_valid;
    logic        bus_we;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wdata,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wdata,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/qar_timer_channel.sv
// One timer channel: configuration, capture synchroniser, compare/PWM/capture events.
module qar_timer_channel
    import qar_timer_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_ctrl,
    input  logic                 wr_cmp,
    input  logic [2:0]           ctrl_wdata,
    input  logic [CNT_WIDTH-1:0] cmp_wdata,
    input  logic                 en,
    input  logic                 tick,
    input  logic                 wrap,
    input  logic [CNT_WIDTH-1:0] count,
    input  logic [CNT_WIDTH-1:0] next_count,
    input  logic                 cap_in,
    output ch_mode_e             mode,
    output logic                 fall,
    output logic [CNT_WIDTH-1:0] cmp,
    output logic [CNT_WIDTH-1:0] cap,
    output logic                 evt_c,
    output logic                 pwm
);

    logic [2:0] sync_q;
    logic       cap_edge_c;

    // Edge on the synchronised input; sync_q[2] holds the previous synchronised value
    always_comb begin
        cap_edge_c = fall ? (sync_q[2] & ~sync_q[1]) : (sync_q[1] & ~sync_q[2]);
    end

    // Event source selected by the channel mode
    always_comb begin
        evt_c = 1'b0;
        case (mode)
            MODE_CMP: evt_c = tick && (next_count == cmp);
            MODE_PWM: evt_c = tick && wrap;
            MODE_CAP: evt_c = cap_edge_c;
            default:  evt_c = 1'b0;
        endcase
    end

    // Config registers, synchroniser, capture latch and registered PWM output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode   <= MODE_OFF;
            fall   <= 1'b0;
            cmp    <= '0;
            cap    <= '0;
            sync_q <= '0;
            pwm    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                mode <= ch_mode_e'(ctrl_wdata[CH_MODE_LSB +: 2]);
                fall <= ctrl_wdata[CH_FALL_BIT];
            end
            if (wr_cmp) begin
                cmp <= cmp_wdata;
            end
            sync_q <= {sync_q[1:0], cap_in};
            if ((mode == MODE_CAP) && cap_edge_c) begin
                cap <= count;
            end
            pwm <= (mode == MODE_PWM) && en && (count < cmp);
        end
    end

endmodule

// File: rtl/qar_timer_mc.sv
// Multi-channel timer: prescaler, reloadable counter, register file and status/irq.
module qar_timer_mc
    import qar_timer_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned PRESC_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    qar_timer_mc_if.slave     bus,
    input  logic [NUM_CH-1:0] cap_in,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              irq,
    input  logic              irq_ack
);

    localparam int unsigned SW = NUM_CH + 1;

    logic                   en;
    logic                   oneshot;
    logic [PRESC_WIDTH-1:0] presc;
    logic [PRESC_WIDTH-1:0] presc_cnt;
    logic [CNT_WIDTH-1:0]   count;
    logic [CNT_WIDTH-1:0]   reload;
    logic [SW-1:0]          status;
    logic [SW-1:0]          irq_en;

    logic                   tick_c;
    logic                   wrap_c;
    logic [CNT_WIDTH-1:0]   next_count_c;
    logic [SW-1:0]          set_c;
    logic [SW-1:0]          clr_c;
    logic [7:0]             addr_c;
    logic [3:0]             ch_sel_c;
    logic [3:0]             sub_c;
    logic                   ch_ok_c;
    logic                   wr_c;
    logic                   wr_ctrl_c, wr_presc_c, wr_count_c, wr_reload_c, wr_status_c, wr_irq_en_c;
    logic [31:0]            rdata_c;
    logic                   unused_addr_bits;

    logic [NUM_CH-1:0]      evt_c;
    ch_mode_e               ch_mode [NUM_CH];
    logic                   ch_fall [NUM_CH];
    logic [CNT_WIDTH-1:0]   ch_cmp  [NUM_CH];
    logic [CNT_WIDTH-1:0]   ch_cap  [NUM_CH];

    // Word-aligned address decode and channel window selection
    assign addr_c           = {bus.bus_addr[7:2], 2'b00};
    assign unused_addr_bits = ^bus.bus_addr[1:0];
    assign ch_sel_c         = bus.bus_addr[7:4] - ADDR_CH_BASE[7:4];
    assign ch_ok_c          = (bus.bus_addr[7:4] >= ADDR_CH_BASE[7:4]) && (32'(ch_sel_c) < NUM_CH);
    assign sub_c            = {bus.bus_addr[3:2], 2'b00};

    assign wr_c        = bus.bus_valid && bus.bus_we;
    assign wr_ctrl_c   = wr_c && (addr_c == ADDR_CTRL);
    assign wr_presc_c  = wr_c && (addr_c == ADDR_PRESC);
    assign wr_count_c  = wr_c && (addr_c == ADDR_COUNT);
    assign wr_reload_c = wr_c && (addr_c == ADDR_RELOAD);
    assign wr_status_c = wr_c && (addr_c == ADDR_STATUS);
    assign wr_irq_en_c = wr_c && (addr_c == ADDR_IRQ_EN);

    // Prescaler tick and counter next value
    assign tick_c       = en && (presc_cnt == presc);
    assign wrap_c       = (count == reload);
    assign next_count_c = wrap_c ? '0 : count + CNT_WIDTH'(1);

    // Flag set/clear vectors; a hardware set overrides any clear below
    always_comb begin
        set_c = '0;
        set_c[STATUS_OVF_BIT] = tick_c && wrap_c;
        set_c[STATUS_CH_LSB +: NUM_CH] = evt_c;
        clr_c = '0;
        if (wr_status_c) begin
            clr_c = SW'(bus.bus_wdata);
        end
        if (irq_ack) begin
            clr_c = clr_c | irq_en;
        end
    end

    // Channel instances
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        qar_timer_channel #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_ctrl    (wr_c && ch_ok_c && (ch_sel_c == 4'(c)) && (sub_c == CH_OFF_CTRL)),
            .wr_cmp     (wr_c && ch_ok_c && (ch_sel_c == 4'(c)) && (sub_c == CH_OFF_CMP)),
            .ctrl_wdata (bus.bus_wdata[2:0]),
            .cmp_wdata  (CNT_WIDTH'(bus.bus_wdata)),
            .en         (en),
            .tick       (tick_c),
            .wrap       (wrap_c),
            .count      (count),
            .next_count (next_count_c),
            .cap_in     (cap_in[c]),
            .mode       (ch_mode[c]),
            .fall       (ch_fall[c]),
            .cmp        (ch_cmp[c]),
            .cap        (ch_cap[c]),
            .evt_c      (evt_c[c]),
            .pwm        (pwm_out[c])
        );
    end

    // Read mux; unmapped addresses return zero
    always_comb begin
        rdata_c = '0;
        case (addr_c)
            ADDR_CTRL: begin
                rdata_c[CTRL_EN_BIT]      = en;
                rdata_c[CTRL_ONESHOT_BIT] = oneshot;
            end
            ADDR_PRESC:  rdata_c = 32'(presc);
            ADDR_COUNT:  rdata_c = 32'(count);
            ADDR_RELOAD: rdata_c = 32'(reload);
            ADDR_STATUS: rdata_c = 32'(status);
            ADDR_IRQ_EN: rdata_c = 32'(irq_en);
            default:     rdata_c = '0;
        endcase
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_ok_c && (ch_sel_c == 4'(c))) begin
                case (sub_c)
                    CH_OFF_CTRL: begin
                        rdata_c[CH_MODE_LSB +: 2] = ch_mode[c];
                        rdata_c[CH_FALL_BIT]      = ch_fall[c];
                    end
                    CH_OFF_CMP: rdata_c = 32'(ch_cmp[c]);
                    CH_OFF_CAP: rdata_c = 32'(ch_cap[c]);
                    default:    rdata_c = '0;
                endcase
            end
        end
    end

    assign bus.bus_ready = bus.bus_valid;
    assign bus.bus_rdata = rdata_c;

    // Control, prescaler, counter, status and irq registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en        <= 1'b0;
            oneshot   <= 1'b0;
            presc     <= '0;
            presc_cnt <= '0;
            count     <= '0;
            reload    <= '0;
            status    <= '0;
            irq_en    <= '0;
            irq       <= 1'b0;
        end else begin
            if (wr_ctrl_c) begin
                en      <= bus.bus_wdata[CTRL_EN_BIT];
                oneshot <= bus.bus_wdata[CTRL_ONESHOT_BIT];
            end else if (tick_c && wrap_c && oneshot) begin
                en <= 1'b0;
            end
            if (wr_ctrl_c || wr_presc_c || !en || tick_c) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + PRESC_WIDTH'(1);
            end
            if (wr_presc_c) begin
                presc <= PRESC_WIDTH'(bus.bus_wdata);
            end
            if (wr_count_c) begin
                count <= CNT_WIDTH'(bus.bus_wdata);
            end else if (tick_c) begin
                count <= next_count_c;
            end
            if (wr_reload_c) begin
                reload <= CNT_WIDTH'(bus.bus_wdata);
            end
            if (wr_irq_en_c) begin
                irq_en <= SW'(bus.bus_wdata);
            end
            status <= (status & ~clr_c) | set_c;
            irq    <= |(status & irq_en);
        end
    end

endmodule

// File: tb/tb_qar_timer_mc.sv
// Directed bench for qar_timer_mc with hand-computed expectations.
module tb_qar_timer_mc;
    import qar_timer_pkg::*;

    localparam int unsigned NUM_CH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] cap_in;
    logic [NUM_CH-1:0] pwm_out;
    logic              irq;
    logic              irq_ack;

    int checks   = 0;
    int failures = 0;

    qar_timer_mc_if bus ();

    qar_timer_mc #(
        .NUM_CH      (NUM_CH),
        .CNT_WIDTH   (32),
        .PRESC_WIDTH (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .cap_in  (cap_in),
        .pwm_out (pwm_out),
        .irq     (irq),
        .irq_ack (irq_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        bus.bus_valid = 1'b1;
        bus.bus_we    = 1'b1;
        bus.bus_addr  = a;
        bus.bus_wdata = d;
        @(posedge clk);
        #1;
        bus.bus_valid = 1'b0;
        bus.bus_we    = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        bus.bus_valid = 1'b1;
        bus.bus_we    = 1'b0;
        bus.bus_addr  = a;
        #1;
        d = bus.bus_rdata;
        bus.bus_valid = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int highs;

        rst_n         = 1'b0;
        cap_in        = '0;
        irq_ack       = 1'b0;
        bus.bus_valid = 1'b0;
        bus.bus_we    = 1'b0;
        bus.bus_addr  = '0;
        bus.bus_wdata = '0;

        // Reset state
        cycles(2);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_pwm", 32'(pwm_out), 32'h0);
        bus.bus_valid = 1'b1;
        #1;
        check("rst_ready", 32'(bus.bus_ready), 32'h1);
        bus.bus_valid = 1'b0;
        rst_n = 1'b1;
        cycles(1);
        rd_check("rst_ctrl", ADDR_CTRL, 32'h0);
        rd_check("rst_count", ADDR_COUNT, 32'h0);
        rd_check("rst_status", ADDR_STATUS, 32'h0);

        // Field widths, ignored address bits and unmapped space
        bus_write(ADDR_PRESC, 32'hFFFF_FFFF);
        rd_check("presc_trunc", ADDR_PRESC, 32'h0000_FFFF);
        bus_write(ADDR_PRESC, 32'h0);
        bus_write(8'h0F, 32'h55);
        rd_check("addr_lsb_ignored", ADDR_RELOAD, 32'h55);
        bus_write(8'h64, 32'h1234);
        rd_check("ch_out_of_range", 8'h64, 32'h0);
        rd_check("unmapped_18", 8'h18, 32'h0);
        bus_write(8'h2C, 32'hABCD);
        rd_check("ch_sub3_unmapped", 8'h2C, 32'h0);
        bus_write(8'h28, 32'h99);
        rd_check("cap_read_only", 8'h28, 32'h0);
        bus_write(8'h20, 32'hFFFF_FFFF);
        rd_check("ch_ctrl_trunc", 8'h20, 32'h7);
        bus_write(8'h20, 32'h0);

        // Free-running overflow with interrupt
        bus_write(ADDR_RELOAD, 32'd9);
        bus_write(ADDR_IRQ_EN, 32'h1);
        bus_write(ADDR_PRESC, 32'h0);
        bus_write(ADDR_CTRL, 32'h1);
        cycles(9);
        rd_check("ovf_count9", ADDR_COUNT, 32'd9);
        rd_check("ovf_not_yet", ADDR_STATUS, 32'h0);
        cycles(1);
        rd_check("ovf_wrap_count", ADDR_COUNT, 32'h0);
        rd_check("ovf_flag", ADDR_STATUS, 32'h1);
        check("ovf_irq_lag", 32'(irq), 32'h0);
        cycles(1);
        check("ovf_irq_high", 32'(irq), 32'h1);
        bus_write(ADDR_STATUS, 32'h1);
        rd_check("ovf_w1c", ADDR_STATUS, 32'h0);
        cycles(1);
        check("ovf_irq_low", 32'(irq), 32'h0);
        bus_write(ADDR_CTRL, 32'h0);
        bus_write(ADDR_COUNT, 32'h0);
        bus_write(ADDR_IRQ_EN, 32'h0);
        bus_write(ADDR_STATUS, 32'hFFFF_FFFF);

        // One-shot with prescaler 3: five ticks of four cycles each
        bus_write(ADDR_RELOAD, 32'd4);
        bus_write(ADDR_PRESC, 32'd3);
        bus_write(ADDR_CTRL, 32'h3);
        cycles(19);
        rd_check("os_before_ovf", ADDR_STATUS, 32'h0);
        rd_check("os_en_still", ADDR_CTRL, 32'h3);
        cycles(1);
        rd_check("os_ovf", ADDR_STATUS, 32'h1);
        rd_check("os_en_cleared", ADDR_CTRL, 32'h2);
        rd_check("os_count0", ADDR_COUNT, 32'h0);
        cycles(10);
        rd_check("os_count_frozen", ADDR_COUNT, 32'h0);
        bus_write(ADDR_CTRL, 32'h0);
        bus_write(ADDR_STATUS, 32'hFFFF_FFFF);

        // PWM on channel 0
        bus_write(8'h20, 32'h2);
        bus_write(8'h24, 32'd3);
        bus_write(ADDR_RELOAD, 32'd7);
        bus_write(ADDR_PRESC, 32'h0);
        bus_write(ADDR_COUNT, 32'h0);
        bus_write(ADDR_CTRL, 32'h1);
        cycles(10);
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            highs += int'(pwm_out[0]);
            cycles(1);
        end
        check("pwm_duty_3of8", 32'(highs), 32'd6);
        check("pwm_other_ch_off", 32'(pwm_out[3:1]), 32'h0);
        rd_check("pwm_wrap_evt", ADDR_STATUS, 32'h3);
        bus_write(8'h24, 32'd8);
        cycles(2);
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            highs += int'(pwm_out[0]);
            cycles(1);
        end
        check("pwm_cmp_gt_reload", 32'(highs), 32'd16);
        bus_write(8'h24, 32'd0);
        cycles(2);
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            highs += int'(pwm_out[0]);
            cycles(1);
        end
        check("pwm_cmp_zero", 32'(highs), 32'd0);
        bus_write(8'h24, 32'd8);
        bus_write(ADDR_CTRL, 32'h0);
        cycles(2);
        check("pwm_en_gate", 32'(pwm_out), 32'h0);
        bus_write(8'h20, 32'h0);
        bus_write(ADDR_STATUS, 32'hFFFF_FFFF);

        // Capture on channel 1 with the counter frozen
        bus_write(ADDR_COUNT, 32'h64);
        bus_write(8'h30, 32'h3);
        bus_write(ADDR_STATUS, 32'hFFFF_FFFF);
        cap_in[1] = 1'b1;
        cycles(5);
        rd_check("cap_rise_value", 8'h38, 32'h0000_0064);
        rd_check("cap_rise_flag", ADDR_STATUS, 32'h4);
        bus_write(8'h30, 32'h7);
        bus_write(ADDR_STATUS, 32'hFFFF_FFFF);
        bus_write(ADDR_COUNT, 32'h77);
        cap_in[1] = 1'b0;
        cycles(5);
        rd_check("cap_fall_value", 8'h38, 32'h0000_0077);
        rd_check("cap_fall_flag", ADDR_STATUS, 32'h4);
        bus_write(8'h30, 32'h0);
        bus_write(ADDR_STATUS, 32'hFFFF_FFFF);

        // Compare on channel 2; W1C lands on the edge that sets the flag
        bus_write(8'h40, 32'h1);
        bus_write(8'h44, 32'd5);
        bus_write(ADDR_RELOAD, 32'hFF);
        bus_write(ADDR_PRESC, 32'h0);
        bus_write(ADDR_COUNT, 32'h0);
        bus_write(ADDR_IRQ_EN, 32'h8);
        bus_write(ADDR_STATUS, 32'hFFFF_FFFF);
        bus_write(ADDR_CTRL, 32'h1);
        cycles(4);
        bus_write(ADDR_STATUS, 32'h8);
        rd_check("cmp_set_wins", ADDR_STATUS, 32'h8);
        cycles(1);
        check("cmp_irq", 32'(irq), 32'h1);
        bus_write(ADDR_CTRL, 32'h0);
        irq_ack = 1'b1;
        cycles(1);
        irq_ack = 1'b0;
        rd_check("cmp_ack_clears", ADDR_STATUS, 32'h0);
        cycles(1);
        check("cmp_irq_cleared", 32'(irq), 32'h0);
        bus_write(8'h40, 32'h0);
        bus_write(ADDR_IRQ_EN, 32'h0);

        // Reset in the middle of counting
        bus_write(8'h20, 32'h2);
        bus_write(8'h24, 32'h80);
        bus_write(8'h40, 32'h1);
        bus_write(8'h44, 32'h31);
        bus_write(ADDR_RELOAD, 32'hFF);
        bus_write(ADDR_IRQ_EN, 32'h1F);
        bus_write(ADDR_COUNT, 32'h0);
        bus_write(ADDR_CTRL, 32'h1);
        cycles(3);
        check("mid_pwm_high", 32'(pwm_out[0]), 32'h1);
        bus_write(ADDR_COUNT, 32'h30);
        rd_check("mid_count30", ADDR_COUNT, 32'h30);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pwm", 32'(pwm_out), 32'h0);
        check("mid_rst_irq", 32'(irq), 32'h0);
        rd_check("mid_rst_count", ADDR_COUNT, 32'h0);
        rd_check("mid_rst_ctrl", ADDR_CTRL, 32'h0);
        rd_check("mid_rst_cmp", 8'h24, 32'h0);
        rd_check("mid_rst_irq_en", ADDR_IRQ_EN, 32'h0);
        cycles(2);
        rst_n = 1'b1;
        cycles(20);
        rd_check("post_rst_status", ADDR_STATUS, 32'h0);
        rd_check("post_rst_count", ADDR_COUNT, 32'h0);
        check("post_rst_irq", 32'(irq), 32'h0);
        check("post_rst_pwm", 32'(pwm_out), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
